gen_word_fifo: RTL
==================

// Module: gen_word_fifo
// PURPOSE
// - Buffering stage directly downstream of the 11-bit per-lane inverter bank (gen/comb00 array).
// - Accepts each inverted word with a valid/ready handshake and stores it in a small first-word-fall-through FIFO.
// - Presents words to the next stage with its own valid/ready handshake.
// - Flags dropped words with a sticky overflow bit.
// - All state is held in plain clocked registers so the block triplicates cleanly under TMRG.
// PARAMETERS
// - WIDTH  11  bits per word; matches the inverter-bank lane count.
// - DEPTH  4   number of entries; must be a power of 2, >= 2.
// - AW     2   pointer address width = log2(DEPTH); derived, not overridden.
// PORTS
// - clk        in   1         single clock; all state changes on posedge.
// - rstn       in   1         asynchronous, active-low reset.
// - in_word    in   WIDTH     word from the inverter bank.
// - in_valid   in   1         in_word is valid this cycle.
// - in_ready   out  1         FIFO can accept a word = !full.
// - out_word   out  WIDTH     head entry; holds 0 while empty.
// - out_valid  out  1         head entry present = !empty.
// - out_ready  in   1         consumer takes the head this cycle.
// - count      out  AW+1      number of stored words, 0..DEPTH.
// - overflow   out  1         sticky: a word was offered while full.
// - clr_ovf    in   1         synchronous clear of overflow.
// BEHAVIOUR
// - Reset (rstn=0, async): wr_ptr=0, rd_ptr=0, count=0, overflow=0, all entries=0.
//   - Outputs during reset: out_valid=0, out_word=0, in_ready=1.
// - Push = in_valid & in_ready: entry[wr_ptr[AW-1:0]] <= in_word; wr_ptr+1.
// - Pop = out_valid & out_ready: rd_ptr+1. A popped entry is cleared to 0.
// - Pointers are AW+1 bits and wrap modulo 2*DEPTH.
//   - empty = (wr_ptr == rd_ptr).
//   - full = MSBs differ and the low AW bits are equal.
// - count = wr_ptr - rd_ptr (AW+1-bit modular subtraction). It is also a registered output, updated with the pointers.
// - Latency: a word pushed into an empty FIFO appears on out_word/out_valid the next cycle. There is no combinational in->out bypass.
// - out_word = entry[rd_ptr[AW-1:0]] (combinational read of registers). It is stable while out_valid=1 and out_ready=0.
// - Simultaneous push and pop, not full and not empty: both happen and count is unchanged.
// - Full: in_ready=0, so no push, even if a pop occurs that same cycle (no full-bypass). in_ready returns to 1 the cycle after the pop.
// - Empty: out_valid=0, so out_ready is ignored and pointers do not move.
// - Overflow: set when in_valid=1 and in_ready=0. Cleared when clr_ovf=1. If set and clear occur in the same cycle, set wins.
// - Reset asserted mid-operation: all contents are discarded immediately. No word is output after reset releases until a new push.
// - No latches. No X on outputs after reset.
// STRUCTURE
// - gen_word_defs.vh: localparams WIDTH_DEF=11, DEPTH_DEF=4, and the AW derivation macro. Shared with gen and the next consumer stage.
// - Sub-module gen_word_reg: one WIDTH-bit entry with async active-low reset, load enable and synchronous clear.
//   - Instantiated DEPTH times in a generate loop labelled entry.
//   - load = push & (wr_ptr[AW-1:0]==i); clr = pop & (rd_ptr[AW-1:0]==i).
// - Top level holds the pointers, count, overflow and the read mux.
// TESTING
// - Reset then idle: out_valid=0, out_word=0, in_ready=1, count=0, overflow=0.
// - Push 0x7FF, 0x000, 0x555, 0x2AA with out_ready=0.
//   - count=4 and in_ready=0 after the 4th push.
//   - Drain with out_ready=1: words appear in push order, one per cycle.
// - Fill to 4 entries, then drive in_valid=1 with 0x123 while full.
//   - overflow=1 and 0x123 is never output.
//   - clr_ovf together with another full offer: overflow stays 1. Next clr_ovf alone clears it.
// - Steady stream: push and pop every cycle for 20 cycles, starting with count=2.
//   - count stays 2 and the output sequence equals the input sequence delayed by 2 words.
//   - Pointers wrap past 2*DEPTH cleanly.
// - Fill to full, then pop and offer 0x0F0 in the same cycle: pop occurs and no push (count=3). Next cycle 0x0F0 is accepted (count=4).
// - Assert rstn=0 mid-stream with count=3: outputs return to reset values asynchronously, and out_valid stays 0 after release until a push.

Source files
------------

// File: rtl/gen_word_fifo_pkg.sv
// Shared sizing for the inverted-word path: the default lane width and FIFO depth,
// plus the pointer-width derivation used by gen_word_fifo and its consumer stage.
package gen_word_fifo_pkg;

    localparam int WIDTH_DEF = 11;
    localparam int DEPTH_DEF = 4;

    function automatic int ptr_aw(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/gen_word_fifo_reg.sv
// One FIFO entry: a WIDTH-bit register with async active-low reset, load enable
// and a synchronous clear so popped slots always read back as zero.
module gen_word_reg #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // A slot is never loaded and popped in the same cycle, but load wins if it ever is.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (clr) begin
            q <= '0;
        end
    end

endmodule

// File: rtl/gen_word_fifo.sv
// First-word-fall-through FIFO behind the inverter bank: valid/ready on both sides,
// registered count, sticky overflow. All state is plain clocked registers (TMR-friendly).
module gen_word_fifo
    import gen_word_fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [WIDTH-1:0]              in_word,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [WIDTH-1:0]              out_word,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ptr_aw(DEPTH):0]        count,
    output logic                          overflow,
    input  logic                          clr_ovf
);

    localparam int AW = ptr_aw(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr_nxt;
    logic [AW:0]      rd_ptr_nxt;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] entry_q [DEPTH];

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    always_comb begin
        empty      = (wr_ptr == rd_ptr);
        full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        in_ready   = !full;
        out_valid  = !empty;
        push       = in_valid && in_ready;
        pop        = out_valid && out_ready;
        wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push};
        rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            count  <= wr_ptr_nxt - rd_ptr_nxt;
        end
    end

    // Set takes priority over clear so an offer in the clearing cycle is not lost.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow <= 1'b0;
        end else if (in_valid && !in_ready) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : entry
        gen_word_reg #(
            .WIDTH(WIDTH)
        ) u_reg (
            .clk (clk),
            .rstn(rstn),
            .load(push && (wr_ptr[AW-1:0] == AW'(i))),
            .clr (pop && (rd_ptr[AW-1:0] == AW'(i))),
            .d   (in_word),
            .q   (entry_q[i])
        );
    end

    // Empty slots are zero, so the head reads 0 whenever the FIFO is empty.
    always_comb begin
        out_word = entry_q[rd_ptr[AW-1:0]];
    end

endmodule
